// File: rtl/muldiv_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters,
// the shared mul_div unit and the response consumer.
interface muldiv_arbiter_if #(
    parameter int TAG_W = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [2:0]       req0_op;
    logic [31:0]      req0_a;
    logic [31:0]      req0_b;
    logic [TAG_W-1:0] req0_tag;

    logic             req1_valid;
    logic             req1_ready;
    logic [2:0]       req1_op;
    logic [31:0]      req1_a;
    logic [31:0]      req1_b;
    logic [TAG_W-1:0] req1_tag;

    logic             flush0;
    logic             flush1;

    logic             md_start;
    logic [2:0]       md_opcode;
    logic [31:0]      md_rs1;
    logic [31:0]      md_rs2;
    logic             md_busy;
    logic             md_ready;
    logic [31:0]      md_result;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [TAG_W-1:0] rsp_tag;
    logic [31:0]      rsp_result;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req0_tag,
        input  req1_valid, req1_op, req1_a, req1_b, req1_tag,
        input  flush0, flush1,
        input  md_busy, md_ready, md_result,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output md_start, md_opcode, md_rs1, md_rs2,
        output rsp_valid, rsp_id, rsp_tag, rsp_result
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req0_tag,
        output req1_valid, req1_op, req1_a, req1_b, req1_tag,
        output flush0, flush1,
        output md_busy, md_ready, md_result,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  md_start, md_opcode, md_rs1, md_rs2,
        input  rsp_valid, rsp_id, rsp_tag, rsp_result
    );
endinterface

// File: rtl/muldiv_arbiter.sv
// Round-robin sharing of one mul_div unit between two
// requesters, with a single buffered, tagged response.
module muldiv_arbiter #(
    parameter int TAG_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    muldiv_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_ptr;
    logic             r_owner;
    logic             r_drop;
    logic [TAG_W-1:0] r_tag;
    logic [2:0]       r_op;
    logic [31:0]      r_rs1;
    logic [31:0]      r_rs2;
    logic [31:0]      r_result;

    logic w_idle;
    logic w_cand0;
    logic w_cand1;
    logic w_gnt0;
    logic w_gnt1;
    logic w_gnt;
    logic w_flush_own;
    logic w_done;
    logic w_keep;

    // Grant is combinational and only ever offered in IDLE.
    assign w_idle  = (r_state == S_IDLE) & ~rst;
    assign w_cand0 = bus.req0_valid & ~bus.flush0;
    assign w_cand1 = bus.req1_valid & ~bus.flush1;
    assign w_gnt0  = w_idle & w_cand0 & (~w_cand1 | r_ptr);
    assign w_gnt1  = w_idle & w_cand1 & (~w_cand0 | ~r_ptr);
    assign w_gnt   = w_gnt0 | w_gnt1;

    // A flush in the completion cycle also drops the result.
    assign w_flush_own = r_owner ? bus.flush1 : bus.flush0;
    assign w_done      = (r_state == S_WAIT) & bus.md_ready;
    assign w_keep      = ~(r_drop | w_flush_own);

    assign bus.req0_ready = w_gnt0;
    assign bus.req1_ready = w_gnt1;
    assign bus.md_opcode  = r_op;
    assign bus.md_rs1     = r_rs1;
    assign bus.md_rs2     = r_rs2;
    assign bus.rsp_id     = r_owner;
    assign bus.rsp_tag    = r_tag;
    assign bus.rsp_result = r_result;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next state plus start pulse and response valid.
    always_comb begin
        w_next        = r_state;
        bus.md_start  = 1'b0;
        bus.rsp_valid = 1'b0;
        if (!rst) begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_gnt) w_next = S_ISSUE;
                end
                S_ISSUE: begin
                    bus.md_start = 1'b1;
                    w_next       = S_WAIT;
                end
                S_WAIT: begin
                    if (bus.md_ready)
                        w_next = w_keep ? S_RESP : S_IDLE;
                end
                S_RESP: begin
                    bus.rsp_valid = 1'b1;
                    if (w_flush_own | bus.rsp_ready)
                        w_next = S_IDLE;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Operand/tag capture, fairness pointer, drop flag, result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr    <= 1'b1;
            r_owner  <= 1'b0;
            r_drop   <= 1'b0;
            r_tag    <= '0;
            r_op     <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_result <= '0;
        end else begin
            if (w_gnt) begin
                r_op    <= w_gnt1 ? bus.req1_op  : bus.req0_op;
                r_rs1   <= w_gnt1 ? bus.req1_a   : bus.req0_a;
                r_rs2   <= w_gnt1 ? bus.req1_b   : bus.req0_b;
                r_tag   <= w_gnt1 ? bus.req1_tag : bus.req0_tag;
                r_owner <= w_gnt1;
                r_ptr   <= w_gnt1;
            end
            if ((r_state == S_ISSUE || r_state == S_WAIT) && w_flush_own)
                r_drop <= 1'b1;
            if (w_done)
                r_drop <= 1'b0;
            if (w_done && w_keep)
                r_result <= bus.md_result;
        end
    end
endmodule

// File: tb/tb_muldiv_arbiter.sv
// Directed bench for muldiv_arbiter with a cycle-accurate
// behavioural mul_div stand-in.
module tb_muldiv_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    muldiv_arbiter_if #(.TAG_W(4)) bus ();

    muldiv_arbiter #(.TAG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] md_lat(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        if (!op[2]) return 6'd1;
        if (b == 32'd0) return 6'd3;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 6'd3;
        return 6'd35;
    endfunction

    function automatic logic [31:0] md_calc(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] xa;
        logic [63:0] xb;
        logic [63:0] p;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        xa  = {{32{a[31]}}, a};
        xb  = (op == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
        if (op == 3'd3) xa = {32'd0, a};
        p = xa * xb;
        case (op)
            3'd0: return p[31:0];
            3'd1, 3'd2, 3'd3: return p[63:32];
            3'd4: return (b == 0) ? 32'hFFFF_FFFF :
                         ovf ? 32'h8000_0000 : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    logic [5:0]  m_cnt;
    logic [31:0] m_res;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt <= 6'd0;
            m_res <= 32'd0;
        end else if (bus.md_start) begin
            m_cnt <= md_lat(bus.md_opcode, bus.md_rs1, bus.md_rs2);
            m_res <= md_calc(bus.md_opcode, bus.md_rs1, bus.md_rs2);
        end else if (bus.md_busy || bus.md_ready) begin
            m_cnt <= m_cnt - 6'd1;
        end
    end

    assign bus.md_ready  = (m_cnt == 6'd1);
    assign bus.md_busy   = (m_cnt > 6'd1);
    assign bus.md_result = m_res;

    always @(negedge clk) begin
        if (bus.md_ready && (bus.md_start || bus.rsp_valid ||
                             bus.req0_ready || bus.req1_ready))
            chk("md_ready_outside_wait", 32'd1, 32'd0);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive(input logic r, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tg);
        if (r) begin
            bus.req1_valid = 1'b1;
            bus.req1_op = op;
            bus.req1_a = a;
            bus.req1_b = b;
            bus.req1_tag = tg;
        end else begin
            bus.req0_valid = 1'b1;
            bus.req0_op = op;
            bus.req0_a = a;
            bus.req0_b = b;
            bus.req0_tag = tg;
        end
    endtask

    task automatic wait_rsp(input string tag);
        for (int w = 0; w < 60; w++) begin
            mid();
            if (bus.rsp_valid) return;
            cyc();
        end
        chk(tag, 32'd0, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic r,
                          input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] tg,
                          input logic [31:0] exp_res, input int exp_lat);
        int lat;
        cyc();
        drive(r, op, a, b, tg);
        mid();
        chk({tag, "_gnt"},
            32'(r ? bus.req1_ready : bus.req0_ready), 32'd1);
        cyc();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        lat = 1;
        while (lat < 80) begin
            mid();
            if (bus.rsp_valid) break;
            cyc();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_res"}, bus.rsp_result, exp_res);
        chk({tag, "_id"}, 32'(bus.rsp_id), 32'(r));
        chk({tag, "_tag"}, 32'(bus.rsp_tag), 32'(tg));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        bus.req0_valid = 1'b0;
        bus.req0_op = 3'd0;
        bus.req0_a = 32'd0;
        bus.req0_b = 32'd0;
        bus.req0_tag = 4'd0;
        bus.req1_valid = 1'b0;
        bus.req1_op = 3'd0;
        bus.req1_a = 32'd0;
        bus.req1_b = 32'd0;
        bus.req1_tag = 4'd0;
        bus.flush0 = 1'b0;
        bus.flush1 = 1'b0;
        bus.rsp_ready = 1'b1;

        // reset state
        repeat (2) cyc();
        mid();
        chk("rst_md_start", 32'(bus.md_start), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_opcode", 32'(bus.md_opcode), 0);
        chk("rst_rs1", bus.md_rs1, 0);
        chk("rst_rs2", bus.md_rs2, 0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 0);
        chk("rst_rsp_tag", 32'(bus.rsp_tag), 0);
        chk("rst_rsp_res", bus.rsp_result, 0);
        chk("rst_readys", 32'({bus.req1_ready, bus.req0_ready}), 0);
        cyc();
        rst = 1'b0;

        // single mul, cycle by cycle
        drive(1'b0, 3'd0, 32'd7, 32'd6, 4'd3);
        mid();
        chk("t1_gnt0", 32'(bus.req0_ready), 1);
        chk("t1_gnt1", 32'(bus.req1_ready), 0);
        chk("t1_start_T", 32'(bus.md_start), 0);
        cyc();
        bus.req0_valid = 1'b0;
        mid();
        chk("t1_start_T1", 32'(bus.md_start), 1);
        chk("t1_rs1", bus.md_rs1, 7);
        chk("t1_rs2", bus.md_rs2, 6);
        chk("t1_op", 32'(bus.md_opcode), 0);
        cyc();
        mid();
        chk("t1_start_T2", 32'(bus.md_start), 0);
        chk("t1_rsp_T2", 32'(bus.rsp_valid), 0);
        cyc();
        mid();
        chk("t1_rsp_T3", 32'(bus.rsp_valid), 1);
        chk("t1_id", 32'(bus.rsp_id), 0);
        chk("t1_tag", 32'(bus.rsp_tag), 3);
        chk("t1_res", bus.rsp_result, 42);
        cyc();
        mid();
        chk("t1_rsp_T4", 32'(bus.rsp_valid), 0);

        // directed op table
        run_op("mulh", 1'b1, 3'd1, 32'h8000_0000, 32'd2, 4'd5,
               32'hFFFF_FFFF, 3);
        run_op("mulhu", 1'b0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               4'd6, 32'hFFFF_FFFE, 3);
        run_op("mulhsu", 1'b1, 3'd2, 32'hFFFF_FFFF, 32'd2, 4'd9,
               32'hFFFF_FFFF, 3);
        run_op("divz", 1'b0, 3'd5, 32'd123, 32'd0, 4'd2,
               32'hFFFF_FFFF, 5);
        run_op("divovf", 1'b1, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF,
               4'd4, 32'h8000_0000, 5);
        run_op("rem", 1'b0, 3'd6, 32'hFFFF_FFF9, 32'd2, 4'd8,
               32'hFFFF_FFFF, 37);

        // div with operand stability
        cyc();
        drive(1'b1, 3'd4, 32'hFFFF_FFF9, 32'd2, 4'hA);
        mid();
        chk("div_gnt", 32'({bus.req1_ready, bus.req0_ready}), 2);
        cyc();
        bus.req1_valid = 1'b0;
        bad = 0;
        for (int c = 1; c <= 36; c++) begin
            mid();
            if (bus.md_opcode != 3'd4 || bus.md_rs1 != 32'hFFFF_FFF9 ||
                bus.md_rs2 != 32'd2) bad++;
            if (bus.md_start != (c == 1)) bad++;
            if (bus.md_ready != (c == 36)) bad++;
            if (bus.rsp_valid) bad++;
            cyc();
        end
        chk("div_stable", 32'(bad), 0);
        mid();
        chk("div_rsp_T37", 32'(bus.rsp_valid), 1);
        chk("div_res", bus.rsp_result, 32'hFFFF_FFFD);
        chk("div_id", 32'(bus.rsp_id), 1);
        chk("div_tag", 32'(bus.rsp_tag), 32'hA);

        // round robin from a fresh pointer
        cyc();
        do_reset();
        cyc();
        drive(1'b0, 3'd0, 32'd3, 32'd5, 4'd1);
        drive(1'b1, 3'd0, 32'd10, 32'd11, 4'd2);
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < 10; w++) begin
                mid();
                if (bus.req0_ready || bus.req1_ready) break;
                cyc();
            end
            chk("rr_grant", 32'({bus.req1_ready, bus.req0_ready}),
                (k % 2) ? 2 : 1);
            cyc();
            wait_rsp("rr_rsp_timeout");
            chk("rr_id", 32'(bus.rsp_id), 32'(k % 2));
            chk("rr_res", bus.rsp_result, (k % 2) ? 110 : 15);
            cyc();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        // response backpressure
        bus.rsp_ready = 1'b0;
        drive(1'b0, 3'd0, 32'd9, 32'd9, 4'd5);
        mid();
        chk("bp_gnt", 32'(bus.req0_ready), 1);
        cyc();
        bus.req0_valid = 1'b0;
        wait_rsp("bp_rsp_timeout");
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (i == 0) begin
                drive(1'b0, 3'd0, 32'd1, 32'd1, 4'd0);
                drive(1'b1, 3'd0, 32'd2, 32'd2, 4'd0);
            end
            mid();
            if (!bus.rsp_valid || bus.rsp_result != 32'd81 ||
                bus.rsp_tag != 4'd5 || bus.rsp_id != 1'b0) bad++;
            if (bus.req0_ready || bus.req1_ready) bad++;
        end
        chk("bp_hold", 32'(bad), 0);
        cyc();
        bus.rsp_ready = 1'b1;
        mid();
        chk("bp_acc_valid", 32'(bus.rsp_valid), 1);
        chk("bp_no_regrant",
            32'({bus.req1_ready, bus.req0_ready}), 0);
        cyc();
        mid();
        chk("bp_after_valid", 32'(bus.rsp_valid), 0);
        chk("bp_regrant", 32'({bus.req1_ready, bus.req0_ready}), 2);
        cyc();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (6) cyc();

        // flush0 during WAIT of a req0 divide
        drive(1'b0, 3'd4, 32'd100, 32'd7, 4'd3);
        mid();
        chk("fl0_gnt", 32'(bus.req0_ready), 1);
        cyc();
        bus.req0_valid = 1'b0;
        repeat (4) cyc();
        bus.flush0 = 1'b1;
        cyc();
        bus.flush0 = 1'b0;
        drive(1'b1, 3'd0, 32'd2, 32'd3, 4'd9);
        bad = 0;
        for (int c = 6; c <= 35; c++) begin
            mid();
            if (bus.req1_ready || bus.rsp_valid) bad++;
            cyc();
        end
        chk("fl0_quiet", 32'(bad), 0);
        mid();
        chk("fl0_mdready", 32'(bus.md_ready), 1);
        chk("fl0_nogrant", 32'(bus.req1_ready), 0);
        chk("fl0_norsp", 32'(bus.rsp_valid), 0);
        cyc();
        mid();
        chk("fl0_grant", 32'(bus.req1_ready), 1);
        chk("fl0_norsp2", 32'(bus.rsp_valid), 0);
        cyc();
        bus.req1_valid = 1'b0;
        wait_rsp("fl0_rsp_timeout");
        chk("fl0_next_id", 32'(bus.rsp_id), 1);
        chk("fl0_next_res", bus.rsp_result, 6);
        chk("fl0_next_tag", 32'(bus.rsp_tag), 9);
        cyc();

        // flush1 while req1 owns the pending response
        bus.rsp_ready = 1'b0;
        drive(1'b1, 3'd0, 32'd4, 32'd4, 4'd7);
        mid();
        chk("fl1_gnt", 32'(bus.req1_ready), 1);
        cyc();
        bus.req1_valid = 1'b0;
        wait_rsp("fl1_rsp_timeout");
        chk("fl1_res", bus.rsp_result, 16);
        cyc();
        bus.flush1 = 1'b1;
        mid();
        chk("fl1_still", 32'(bus.rsp_valid), 1);
        cyc();
        bus.flush1 = 1'b0;
        mid();
        chk("fl1_dropped", 32'(bus.rsp_valid), 0);
        bus.rsp_ready = 1'b1;

        // flush1 while req0 owns: no effect
        cyc();
        bus.rsp_ready = 1'b0;
        bus.flush1 = 1'b1;
        drive(1'b0, 3'd0, 32'd5, 32'd5, 4'd4);
        mid();
        chk("nf_gnt", 32'(bus.req0_ready), 1);
        cyc();
        bus.req0_valid = 1'b0;
        wait_rsp("nf_rsp_timeout");
        chk("nf_id", 32'(bus.rsp_id), 0);
        chk("nf_res", bus.rsp_result, 25);
        cyc();
        mid();
        chk("nf_held", 32'(bus.rsp_valid), 1);
        cyc();
        bus.flush1 = 1'b0;
        bus.rsp_ready = 1'b1;
        mid();
        chk("nf_acc", 32'(bus.rsp_valid), 1);
        cyc();
        mid();
        chk("nf_gone", 32'(bus.rsp_valid), 0);

        // reset in the middle of a divide
        cyc();
        drive(1'b0, 3'd4, 32'd1000, 32'd3, 4'd1);
        mid();
        chk("rd_gnt", 32'(bus.req0_ready), 1);
        cyc();
        bus.req0_valid = 1'b0;
        repeat (8) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        mid();
        chk("rd_start", 32'(bus.md_start), 0);
        chk("rd_op", 32'(bus.md_opcode), 0);
        chk("rd_rs1", bus.md_rs1, 0);
        chk("rd_rs2", bus.md_rs2, 0);
        chk("rd_rsp", 32'(bus.rsp_valid), 0);
        chk("rd_mdready", 32'(bus.md_ready), 0);
        run_op("rd_mul", 1'b0, 3'd0, 32'd6, 32'd7, 4'd2, 42, 3);
        cyc();
        repeat (2) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_arbiter.md
Name: muldiv_arbiter

Overview:
- Shares one `mul_div` unit between two requesters, e.g. two issue slots or an integer pipe plus a debug/microcode port.
- Accepts operations through valid/ready handshakes and arbitrates round-robin.
- Holds the opcode and operands stable for the whole operation, generates the single-cycle `start` pulse and waits for `ready`.
- Returns the result on one buffered response channel tagged with requester id and tag. Also supports per-requester flush of in-flight work.

Parameters:
- TAG_W, 4, width of the requester-supplied tag echoed on the response.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  3  M-ext funct3 encoding (0–3 mul family, 4–7 div/rem).
- req0_a, req0_b  in  32  operands.
- req0_tag  in  TAG_W  opaque tag.
- req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_tag: same as requester 0.
- flush0, flush1  in  1  discard any in-flight or pending-response work owned by that requester.
- md_start  out  1  start pulse to `mul_div`.
- md_opcode  out  3  to `mul_div`.
- md_rs1, md_rs2  out  32  to `mul_div`.
- md_busy  in  1  from `mul_div` (monitor only).
- md_ready  in  1  from `mul_div`.
- md_result  in  32  from `mul_div`.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  owning requester.
- rsp_tag  out  TAG_W  echoed tag.
- rsp_result  out  32  result.

Behaviour:
- Reset values:
  - state = IDLE.
  - All outputs 0: req*_ready, md_start, md_opcode, md_rs1, md_rs2, rsp_valid, rsp_id, rsp_tag, rsp_result.
  - Round-robin pointer = 1 (last grant = req1), so req0 wins the first tie.
  - Drop flag = 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Candidates are the reqN_valid inputs whose flushN is low.
  - If only one is a candidate, grant it. If both are, grant the one not granted last.
  - Grant is combinational: reqN_ready = 1 in the same cycle only for the granted requester. reqN_ready is never 1 outside IDLE.
  - On grant, register op, a and b into md_opcode, md_rs1 and md_rs2. Also register tag, owner id and the pointer update, then go to ISSUE.
- ISSUE:
  - md_start = 1 for exactly this one cycle. Next state is WAIT.
- WAIT:
  - md_start = 0. md_opcode, md_rs1 and md_rs2 stay stable until exit, because `mul_div` samples them in its INIT and DONE states.
  - When md_ready = 1:
    - if the drop flag is set, clear it and go to IDLE with no response;
    - otherwise capture md_result into rsp_result and go to RESP.
- RESP:
  - rsp_valid = 1, with rsp_id, rsp_tag and rsp_result held stable.
  - On rsp_valid & rsp_ready, go to IDLE; rsp_valid is 0 the next cycle.
  - There is no same-cycle re-grant: a new grant can occur at the earliest in the cycle after the response is accepted.
- Flush:
  - flushN = 1 in ISSUE or WAIT while the owner is N sets the drop flag. The `mul_div` operation still runs to completion, since it cannot be aborted.
  - flushN = 1 in RESP while the owner is N drops the response: go to IDLE, rsp_valid = 0 the next cycle, even if rsp_ready is 1 that cycle.
  - A flush for the non-owner has no effect.
- Latency, with acceptance in cycle T:
  - md_start in T+1.
  - mul ops (op 0–3): md_ready in T+2, rsp_valid from T+3.
  - div/rem: md_ready in T+36, rsp_valid from T+37.
  - divide by zero and signed overflow: md_ready in T+4, rsp_valid from T+5.
- md_ready seen in IDLE, ISSUE or RESP is ignored; it is a protocol error and is flagged by a bench assertion.
- Reset mid-operation: all state clears within one cycle. `mul_div` shares rst, so no stale md_ready is expected.

Test Plan:
- Mul, single requester: req0 valid, op=0, a=7, b=6, tag=3 at T -> req0_ready at T; md_start at T+1 only; rsp_valid at T+3 with id=0, tag=3, result=42.
- Round-robin: req0 and req1 both held valid with op=0, rsp_ready=1.
  - Grants go req0, req1, req0, ….
  - Results match each requester's operands.
  - No requester is granted twice in a row while the other is waiting.
- Div and stability: req1 op=4, a=0xFFFFFFF9 (-7), b=2.
  - md_rs1, md_rs2 and md_opcode are constant T+1..T+36.
  - rsp at T+37, result=0xFFFFFFFD (-3).
  - Divide by zero: op=5, b=0 -> result=0xFFFFFFFF at T+5.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid.
  - Response is held unchanged.
  - req0_ready and req1_ready stay 0.
  - A new grant occurs only after the accept cycle.
- Flush:
  - flush0 pulsed in WAIT of a req0 div -> no response ever; the next grant is possible only after md_ready.
  - flush1 in RESP of a req1 response -> rsp_valid drops next cycle.
  - flush1 while owner is 0 -> no effect.
- Reset mid-div: rst asserted in WAIT -> the next cycle shows IDLE, all outputs 0; a fresh mul completes with normal T+3 latency.
